vliw_regfile_mp: RTL and testbench
==================================

# vliw_regfile_mp

Parametrised multi-ported register file for the VLIW core. It is the successor to the fixed four-unit, 32×32b file. Read-port count, write-port count, register count and width are all parameters. It adds optional same-cycle write-to-read bypass, deterministic write-conflict resolution with error reporting, and a per-register pending-write scoreboard that the issue stage uses for RAW/WAW hazard checks across bundle slots. It sits between the bundle decode/issue stage and the functional units (LSU, IXUs, branch).

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of 2, ≥ 2); AW = $clog2(NREGS)
- NRD, 8, number of read ports
- NWR, 4, number of write ports; port index is slot priority, the highest index wins
- BYPASS, 1, 1 = a write is visible to same-cycle reads; 0 = reads return the pre-edge value
- CNT_W, 8, width of the conflict counter

Ports:
- clk  in  1  single clock; everything samples on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses; port j is at [j*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational from rd_addr
- rd_busy  out  NRD  combinational pending-write flag for each read address
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- rsv_en  in  NWR  scoreboard reservation enables, driven by issue
- rsv_addr  in  NWR*AW  destination registers to mark pending
- conflict  out  1  registered pulse: a multi-port write conflict occurred in the previous cycle
- conflict_cnt  out  CNT_W  saturating count of cycles that had a conflict

## Operation
- Storage: NREGS×XLEN flops. Register 0 is hardwired to zero: writes to it are dropped, reads return 0, it is never busy, and reservations to it are ignored.
- Write resolution per edge: for each register r≠0, if any wr_en[i] is set with wr_addr[i]==r, then r takes wr_data from the highest such i.
- Conflict: a cycle is a conflict cycle if two or more enabled write ports target the same nonzero address.
  - conflict is set to 1 for exactly the following cycle.
  - conflict_cnt increments by 1 per conflict cycle, regardless of how many ports collide, and saturates at 2^CNT_W−1.
  - Writes to register 0 never count as a conflict.
- Reads with BYPASS=1: if any enabled write targets rd_addr[j]≠0 this cycle, rd_data[j] is that cycle's winning wr_data. Otherwise it is the stored value.
- Reads with BYPASS=0: rd_data[j] is always the stored value.
- Scoreboard: one busy bit per register.
  - rsv_en[i] sets busy[rsv_addr[i]] at the edge.
  - An enabled write to r clears busy[r] at the edge.
  - If a set and a clear hit the same r in the same cycle, the set wins, because the reservation belongs to a younger bundle.
  - Multiple reservations to the same r are legal and simply set the bit. The reservation path does no conflict counting.
- rd_busy[j] = busy[rd_addr[j]], except:
  - with BYPASS=1 it is forced to 0 when an enabled write hits rd_addr[j] this cycle;
  - it is always 0 for register 0.

## Timing
- Read latency: 0 cycles (combinational). Write latency: the value is visible in storage after 1 edge, or in the same cycle with BYPASS=1.
- busy set or clear takes effect after 1 edge. rd_busy reflects the updated state in the next cycle.
- conflict and conflict_cnt are registered and lag the offending cycle by 1 edge.
- Reset: on any edge with rst=1:
  - all registers, busy bits, conflict and conflict_cnt go to 0;
  - wr_en and rsv_en in that cycle are ignored, even if rst rises mid-operation.
- Outputs after reset:
  - rd_data is 0 for every address;
  - rd_busy is 0, except that with BYPASS=1 a write on the first post-reset cycle still forwards.
- No backpressure and no handshake: all ports are accepted every cycle. The issue stage must use rd_busy to stall.

## Test plan
- Reset and zero register:
  - after rst, all ports reading r0..r31 return 0;
  - write 32'hDEAD_BEEF to r0 on every port, then read r0: returns 0, conflict stays 0, busy[0] stays 0.
- Priority and conflict:
  - ports 0, 1 and 3 all write r5 with 32'h1, 32'h2 and 32'h3 in one cycle;
  - next cycle: r5 reads 32'h3, conflict=1, conflict_cnt=1;
  - the cycle after, conflict returns to 0.
- Bypass:
  - with BYPASS=1, write r7=32'hA5A5_0001 while reading r7 on the same cycle: read returns 32'hA5A5_0001;
  - with BYPASS=0, the same stimulus returns the old value 0, and the new value appears the next cycle.
- Scoreboard:
  - reserve r9: rd_busy=1 on the next cycle;
  - write r9 while reserving r9 in the same cycle: busy stays 1;
  - write r9 alone: busy drops to 0 on the next cycle.
- Saturation:
  - with CNT_W=2, drive 5 consecutive conflict cycles: conflict_cnt goes 1, 2, 3, 3, 3.
- Reset mid-operation:
  - assert rst in the same cycle as writes to r4 and a reservation of r4;
  - next cycle: r4=0, busy[4]=0, conflict_cnt=0.

Source files
------------

// File: rtl/vliw_regfile_mp_if.sv
// Bundle between the issue stage (master) and the multi-ported register file (slave).
interface vliw_regfile_mp_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned NRD   = 8,
   parameter int unsigned NWR   = 4,
   parameter int unsigned CNT_W = 8
);
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NWR-1:0]      rsv_en;
   logic [NWR*AW-1:0]   rsv_addr;
   logic                conflict;
   logic [CNT_W-1:0]    conflict_cnt;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, conflict, conflict_cnt
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, conflict, conflict_cnt
   );
endinterface

// File: rtl/vliw_regfile_mp.sv
// Parametrised multi-ported register file with optional write-to-read bypass,
// slot-priority write resolution, conflict counting and a pending-write scoreboard.
module vliw_regfile_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NRD    = 8,
   parameter int unsigned NWR    = 4,
   parameter int unsigned BYPASS = 1,
   parameter int unsigned CNT_W  = 8
) (
   input logic              clk,
   input logic              rst,
   vliw_regfile_mp_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);

   logic [NREGS-1:0][XLEN-1:0] regs_q;
   logic [NREGS-1:0]           busy_q;
   logic [NREGS-1:0]           busy_d;
   logic                       conflict_q;
   logic [CNT_W-1:0]           cnt_q;

   logic [NREGS-1:0]           wr_hit;
   logic [NREGS-1:0][XLEN-1:0] wr_val;
   logic                       conflict_now;
   logic [NREGS-1:0]           rsv_set;

   // Resolve write ports per register; the ascending scan lets the highest slot win,
   // and a second hit on an already-claimed register flags a conflict. r0 never claims.
   always_comb begin
      wr_hit       = '0;
      wr_val       = '0;
      conflict_now = 1'b0;
      for (int unsigned i = 0; i < NWR; i++) begin
         if (bus.wr_en[i] && (bus.wr_addr[i*AW +: AW] != '0)) begin
            if (wr_hit[bus.wr_addr[i*AW +: AW]]) begin
               conflict_now = 1'b1;
            end
            wr_hit[bus.wr_addr[i*AW +: AW]] = 1'b1;
            wr_val[bus.wr_addr[i*AW +: AW]] = bus.wr_data[i*XLEN +: XLEN];
         end
      end
   end

   // Scoreboard next state: writes clear, reservations set, and a set beats a clear.
   always_comb begin
      rsv_set = '0;
      for (int unsigned i = 0; i < NWR; i++) begin
         if (bus.rsv_en[i]) begin
            rsv_set[bus.rsv_addr[i*AW +: AW]] = 1'b1;
         end
      end
      rsv_set[0] = 1'b0;
      busy_d     = (busy_q & ~wr_hit) | rsv_set;
   end

   // Combinational read ports with optional same-cycle forwarding of the winning write.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int unsigned j = 0; j < NRD; j++) begin
         if ((BYPASS != 0) && wr_hit[bus.rd_addr[j*AW +: AW]]) begin
            bus.rd_data[j*XLEN +: XLEN] = wr_val[bus.rd_addr[j*AW +: AW]];
            bus.rd_busy[j]              = 1'b0;
         end else begin
            bus.rd_data[j*XLEN +: XLEN] = regs_q[bus.rd_addr[j*AW +: AW]];
            bus.rd_busy[j]              = busy_q[bus.rd_addr[j*AW +: AW]];
         end
      end
   end

   // Storage, scoreboard and conflict bookkeeping; reset discards that cycle's traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q     <= '0;
         busy_q     <= '0;
         conflict_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         for (int unsigned r = 1; r < NREGS; r++) begin
            if (wr_hit[r]) begin
               regs_q[r] <= wr_val[r];
            end
         end
         busy_q     <= busy_d;
         conflict_q <= conflict_now;
         if (conflict_now && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.conflict     = conflict_q;
   assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_vliw_regfile_mp.sv
// Bench for vliw_regfile_mp: three instances (bypass, no bypass, 2-bit counter)
// share one stimulus stream and are checked against an array-based model.
module tb_vliw_regfile_mp;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 8;
   localparam int NWR   = 4;
   localparam int NDUT  = 3;

   logic clk;
   logic rst;

   // Stimulus in unpacked form; packed into the buses below.
   logic [AW-1:0]   t_rd_addr  [NRD];
   logic            t_wr_en    [NWR];
   logic [AW-1:0]   t_wr_addr  [NWR];
   logic [XLEN-1:0] t_wr_data  [NWR];
   logic            t_rsv_en   [NWR];
   logic [AW-1:0]   t_rsv_addr [NWR];

   logic [NRD*AW-1:0]   p_rd_addr;
   logic [NWR-1:0]      p_wr_en;
   logic [NWR*AW-1:0]   p_wr_addr;
   logic [NWR*XLEN-1:0] p_wr_data;
   logic [NWR-1:0]      p_rsv_en;
   logic [NWR*AW-1:0]   p_rsv_addr;

   // Observed outputs: index 0 = bypass, 1 = no bypass, 2 = bypass with 2-bit counter.
   logic [XLEN-1:0] act_data [NDUT][NRD];
   logic            act_busy [NDUT][NRD];
   logic            act_conf [NDUT];
   logic [31:0]     act_cnt  [NDUT];
   bit              dut_byp  [NDUT] = '{1'b1, 1'b0, 1'b1};
   int              dut_cw   [NDUT] = '{8, 8, 2};

   // Reference model.
   logic [XLEN-1:0] m_reg  [NREGS];
   bit              m_busy [NREGS];
   bit              m_conf;
   int              m_cnt;

   int checks = 0;
   int errors = 0;

   vliw_regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR), .CNT_W(8)) if_byp ();
   vliw_regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR), .CNT_W(8)) if_nob ();
   vliw_regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR), .CNT_W(2)) if_sat ();

   vliw_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .CNT_W(8))
      u_byp (.clk(clk), .rst(rst), .bus(if_byp.slave));
   vliw_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .CNT_W(8))
      u_nob (.clk(clk), .rst(rst), .bus(if_nob.slave));
   vliw_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .CNT_W(2))
      u_sat (.clk(clk), .rst(rst), .bus(if_sat.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      p_rd_addr  = '0;
      p_wr_en    = '0;
      p_wr_addr  = '0;
      p_wr_data  = '0;
      p_rsv_en   = '0;
      p_rsv_addr = '0;
      for (int j = 0; j < NRD; j++) p_rd_addr[j*AW +: AW] = t_rd_addr[j];
      for (int i = 0; i < NWR; i++) begin
         p_wr_en[i]                = t_wr_en[i];
         p_wr_addr[i*AW +: AW]     = t_wr_addr[i];
         p_wr_data[i*XLEN +: XLEN] = t_wr_data[i];
         p_rsv_en[i]               = t_rsv_en[i];
         p_rsv_addr[i*AW +: AW]    = t_rsv_addr[i];
      end
   end

   assign if_byp.rd_addr = p_rd_addr;   assign if_nob.rd_addr = p_rd_addr;
   assign if_sat.rd_addr = p_rd_addr;
   assign if_byp.wr_en   = p_wr_en;     assign if_nob.wr_en   = p_wr_en;
   assign if_sat.wr_en   = p_wr_en;
   assign if_byp.wr_addr = p_wr_addr;   assign if_nob.wr_addr = p_wr_addr;
   assign if_sat.wr_addr = p_wr_addr;
   assign if_byp.wr_data = p_wr_data;   assign if_nob.wr_data = p_wr_data;
   assign if_sat.wr_data = p_wr_data;
   assign if_byp.rsv_en  = p_rsv_en;    assign if_nob.rsv_en  = p_rsv_en;
   assign if_sat.rsv_en  = p_rsv_en;
   assign if_byp.rsv_addr = p_rsv_addr; assign if_nob.rsv_addr = p_rsv_addr;
   assign if_sat.rsv_addr = p_rsv_addr;

   always_comb begin
      for (int j = 0; j < NRD; j++) begin
         act_data[0][j] = if_byp.rd_data[j*XLEN +: XLEN];
         act_data[1][j] = if_nob.rd_data[j*XLEN +: XLEN];
         act_data[2][j] = if_sat.rd_data[j*XLEN +: XLEN];
         act_busy[0][j] = if_byp.rd_busy[j];
         act_busy[1][j] = if_nob.rd_busy[j];
         act_busy[2][j] = if_sat.rd_busy[j];
      end
      act_conf[0] = if_byp.conflict;
      act_conf[1] = if_nob.conflict;
      act_conf[2] = if_sat.conflict;
      act_cnt[0]  = 32'(if_byp.conflict_cnt);
      act_cnt[1]  = 32'(if_nob.conflict_cnt);
      act_cnt[2]  = 32'(if_sat.conflict_cnt);
   end

   // Highest-numbered enabled write port targeting a (nonzero) register, or -1.
   function automatic int winner(int a);
      if (a == 0) return -1;
      for (int i = NWR - 1; i >= 0; i--) begin
         if (t_wr_en[i] && (int'(t_wr_addr[i]) == a)) return i;
      end
      return -1;
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(int a, bit byp);
      int w;
      w = winner(a);
      if (a == 0) return '0;
      if (byp && (w >= 0)) return t_wr_data[w];
      return m_reg[a];
   endfunction

   function automatic bit exp_busy(int a, bit byp);
      if (a == 0) return 1'b0;
      if (byp && (winner(a) >= 0)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [31:0] exp_cnt(int w);
      int sat;
      sat = (1 << w) - 1;
      return (m_cnt > sat) ? 32'(sat) : 32'(m_cnt);
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      int hits;
      int w;
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
         end
         m_conf = 1'b0;
         m_cnt  = 0;
         return;
      end
      m_conf = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         hits = 0;
         for (int i = 0; i < NWR; i++) if (t_wr_en[i] && (int'(t_wr_addr[i]) == r)) hits++;
         if (hits >= 2) m_conf = 1'b1;
         w = winner(r);
         if (w >= 0) begin
            m_reg[r]  = t_wr_data[w];
            m_busy[r] = 1'b0;
         end
      end
      for (int i = 0; i < NWR; i++) begin
         if (t_rsv_en[i] && (t_rsv_addr[i] != '0)) m_busy[t_rsv_addr[i]] = 1'b1;
      end
      if (m_conf) m_cnt++;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int j = 0; j < NRD; j++) t_rd_addr[j] = '0;
      for (int i = 0; i < NWR; i++) begin
         t_wr_en[i]    = 1'b0;
         t_wr_addr[i]  = '0;
         t_wr_data[i]  = '0;
         t_rsv_en[i]   = 1'b0;
         t_rsv_addr[i] = '0;
      end
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      for (int i = 0; i < NWR; i++) begin
         t_wr_en[i]    = 1'b1;
         t_wr_addr[i]  = AW'(i + 1);
         t_wr_data[i]  = $urandom;
         t_rsv_en[i]   = 1'b1;
         t_rsv_addr[i] = AW'(i + 10);
      end
      tick();
      rst = 1'b0;
      idle();
      for (int g = 0; g < NREGS / NRD; g++) begin
         for (int j = 0; j < NRD; j++) t_rd_addr[j] = AW'(g * NRD + j);
         #1;
         for (int d = 0; d < NDUT; d++) begin
            for (int j = 0; j < NRD; j++) begin
               checks++;
               if (act_data[d][j] !== '0 || act_busy[d][j] !== 1'b0) begin
                  errors++;
                  $display("FAIL reset_read dut%0d r%0d: got %h/%b required 0/0",
                           d, g * NRD + j, act_data[d][j], act_busy[d][j]);
               end
            end
            checks++;
            if (act_conf[d] !== 1'b0 || act_cnt[d] !== 32'd0) begin
               errors++;
               $display("FAIL reset_conflict dut%0d: got %b/%0d required 0/0",
                        d, act_conf[d], act_cnt[d]);
            end
         end
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      for (int i = 0; i < NWR; i++) begin
         t_wr_en[i]   = 1'b1;
         t_wr_data[i] = 32'hDEAD_BEEF;
         t_rsv_en[i]  = 1'b1;
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_data[d][0] !== '0 || act_busy[d][0] !== 1'b0) begin
            errors++;
            $display("FAIL r0_same_cycle dut%0d: got %h/%b required 0/0",
                     d, act_data[d][0], act_busy[d][0]);
         end
      end
      tick();
      idle();
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_data[d][0] !== '0 || act_busy[d][0] !== 1'b0 || act_conf[d] !== 1'b0) begin
            errors++;
            $display("FAIL r0_after dut%0d: got %h/%b/%b required 0/0/0",
                     d, act_data[d][0], act_busy[d][0], act_conf[d]);
         end
      end
   endtask

   task automatic test_priority();
      do_reset();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd5; t_wr_data[0] = 32'h1;
      t_wr_en[1] = 1'b1; t_wr_addr[1] = 5'd5; t_wr_data[1] = 32'h2;
      t_wr_en[3] = 1'b1; t_wr_addr[3] = 5'd5; t_wr_data[3] = 32'h3;
      tick();
      idle();
      t_rd_addr[2] = 5'd5;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_data[d][2] !== 32'h3 || act_conf[d] !== 1'b1 || act_cnt[d] !== 32'd1) begin
            errors++;
            $display("FAIL priority dut%0d: got %h/%b/%0d required 00000003/1/1",
                     d, act_data[d][2], act_conf[d], act_cnt[d]);
         end
      end
      tick();
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_conf[d] !== 1'b0 || act_cnt[d] !== 32'd1) begin
            errors++;
            $display("FAIL conflict_pulse dut%0d: got %b/%0d required 0/1",
                     d, act_conf[d], act_cnt[d]);
         end
      end
   endtask

   task automatic test_bypass();
      do_reset();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd7; t_wr_data[0] = 32'hA5A5_0001;
      t_rd_addr[0] = 5'd7;
      #1;
      checks++;
      if (act_data[0][0] !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL bypass_on: got %h required a5a50001", act_data[0][0]);
      end
      checks++;
      if (act_data[1][0] !== 32'h0) begin
         errors++;
         $display("FAIL bypass_off_same: got %h required 00000000", act_data[1][0]);
      end
      tick();
      t_wr_en[0] = 1'b0;
      #1;
      checks++;
      if (act_data[1][0] !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL bypass_off_next: got %h required a5a50001", act_data[1][0]);
      end
   endtask

   task automatic test_scoreboard();
      do_reset();
      t_rsv_en[2] = 1'b1; t_rsv_addr[2] = 5'd9;
      t_rd_addr[0] = 5'd9;
      tick();
      t_rsv_en[2] = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_busy[d][0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_reserve dut%0d: got %b required 1", d, act_busy[d][0]);
         end
      end
      t_wr_en[1] = 1'b1; t_wr_addr[1] = 5'd9; t_wr_data[1] = $urandom;
      t_rsv_en[0] = 1'b1; t_rsv_addr[0] = 5'd9;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_busy[d][0] !== !dut_byp[d]) begin
            errors++;
            $display("FAIL sb_fwd_busy dut%0d: got %b required %b", d, act_busy[d][0],
                     !dut_byp[d]);
         end
      end
      tick();
      t_wr_en[1] = 1'b0; t_rsv_en[0] = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_busy[d][0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins dut%0d: got %b required 1", d, act_busy[d][0]);
         end
      end
      t_wr_en[3] = 1'b1; t_wr_addr[3] = 5'd9; t_wr_data[3] = $urandom;
      tick();
      t_wr_en[3] = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_busy[d][0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear dut%0d: got %b required 0", d, act_busy[d][0]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [31:0] exp_sat [5];
      exp_sat = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd3; t_wr_data[0] = $urandom;
         t_wr_en[2] = 1'b1; t_wr_addr[2] = 5'd3; t_wr_data[2] = $urandom;
         tick();
         checks++;
         if (act_cnt[2] !== exp_sat[k] || act_cnt[0] !== 32'(k + 1) || act_conf[2] !== 1'b1) begin
            errors++;
            $display("FAIL saturation step%0d: got %0d/%0d/%b required %0d/%0d/1",
                     k, act_cnt[2], act_cnt[0], act_conf[2], exp_sat[k], k + 1);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 5'd4; t_wr_data[0] = 32'h1234_5678;
      t_wr_en[1] = 1'b1; t_wr_addr[1] = 5'd6; t_wr_data[1] = 32'h11;
      t_wr_en[2] = 1'b1; t_wr_addr[2] = 5'd6; t_wr_data[2] = 32'h22;
      t_rsv_en[0] = 1'b1; t_rsv_addr[0] = 5'd10;
      tick();
      idle();
      rst = 1'b1;
      for (int i = 0; i < NWR; i++) begin
         t_wr_en[i] = 1'b1; t_wr_addr[i] = 5'd4; t_wr_data[i] = $urandom | 32'h1;
      end
      t_rsv_en[1] = 1'b1; t_rsv_addr[1] = 5'd4;
      tick();
      rst = 1'b0;
      idle();
      t_rd_addr[0] = 5'd4;
      t_rd_addr[1] = 5'd10;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (act_data[d][0] !== '0 || act_busy[d][0] !== 1'b0 || act_busy[d][1] !== 1'b0 ||
             act_cnt[d] !== 32'd0 || act_conf[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid dut%0d: got %h/%b/%b/%0d/%b required 0/0/0/0/0",
                     d, act_data[d][0], act_busy[d][0], act_busy[d][1], act_cnt[d],
                     act_conf[d]);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < NWR; i++) begin
            t_wr_en[i]    = $urandom_range(0, 1);
            t_wr_addr[i]  = AW'($urandom_range(0, 7));
            t_wr_data[i]  = $urandom;
            t_rsv_en[i]   = ($urandom_range(0, 3) == 0);
            t_rsv_addr[i] = AW'($urandom_range(0, 7));
         end
         for (int j = 0; j < NRD; j++) begin
            t_rd_addr[j] = ($urandom_range(0, 3) == 0) ? AW'($urandom) :
                                                         AW'($urandom_range(0, 7));
         end
         #1;
         for (int d = 0; d < NDUT; d++) begin
            for (int j = 0; j < NRD; j++) begin
               checks++;
               if (act_data[d][j] !== exp_rd(int'(t_rd_addr[j]), dut_byp[d]) ||
                   act_busy[d][j] !== exp_busy(int'(t_rd_addr[j]), dut_byp[d])) begin
                  errors++;
                  $display("FAIL rand_read c%0d dut%0d port%0d r%0d: got %h/%b required %h/%b",
                           c, d, j, t_rd_addr[j], act_data[d][j], act_busy[d][j],
                           exp_rd(int'(t_rd_addr[j]), dut_byp[d]),
                           exp_busy(int'(t_rd_addr[j]), dut_byp[d]));
               end
            end
            checks++;
            if (act_conf[d] !== m_conf || act_cnt[d] !== exp_cnt(dut_cw[d])) begin
               errors++;
               $display("FAIL rand_conflict c%0d dut%0d: got %b/%0d required %b/%0d",
                        c, d, act_conf[d], act_cnt[d], m_conf, exp_cnt(dut_cw[d]));
            end
         end
         tick();
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_zero_reg();
      test_priority();
      test_bypass();
      test_scoreboard();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
